ecpri_rma_rx: RTL

Receive-side parser for eCPRI Remote Memory Access (message type 0x04) requests carried over UDP. It consumes a byte stream from the ingress FIFO, skips a fixed L2/L3/L4 header and validates the eCPRI common header. Write payloads go to a local memory port; each request produces one response descriptor for the tx block. It generalises the earlier fixed-width rx handler with parametrised address, header offset and length limits, a valid/ready handshake, range checks, error status and counters.

---
 rtl/ecpri_rma_rx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ecpri_rma_rx.sv
// eCPRI Remote Memory Access request parser: skips the L2-L4 header, validates the
// eCPRI/RMA header, writes payload bytes to local memory and emits one response descriptor.
module ecpri_rma_rx #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int HDR_SKIP   = 42,
  parameter int MAX_LEN    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  input  logic                  s_sop,
  input  logic                  s_eop,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_is_write,
  output logic [7:0]            resp_rma_id,
  output logic [15:0]           resp_elem_id,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [LEN_WIDTH-1:0]  resp_len,
  output logic [1:0]            resp_status,
  output logic [15:0]           err_cnt,
  output logic [15:0]           pkt_cnt
);
  typedef enum logic [2:0] {IDLE, SKIP, CMN, RMA, WR_DATA, DRAIN, RESP} state_t;

  localparam logic [1:0]            ST_OK        = 2'd0;
  localparam logic [1:0]            ST_BAD_RANGE = 2'd2;
  localparam logic [1:0]            ST_TRUNC     = 2'd3;
  localparam logic [LEN_WIDTH-1:0]  SKIP_LAST    = LEN_WIDTH'(HDR_SKIP - 1);
  localparam logic [LEN_WIDTH-1:0]  LEN_MAX      = LEN_WIDTH'(MAX_LEN);
  localparam logic [ADDR_WIDTH:0]   ADDR_SPAN    = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] idx;        // byte index within SKIP, the eCPRI header, or the data phase
  logic [3:0]           off;
  logic                 resp_pend;  // current packet owes a response descriptor
  logic                 acc, hdr_bad, range_bad, wr_go, last_data, err_inc, pkt_inc;
  logic [LEN_WIDTH-1:0] len_full;
  logic [ADDR_WIDTH:0]  end_addr;

  assign s_ready    = !reset && (state != RESP);
  assign resp_valid = (state == RESP);
  assign acc        = s_valid && s_ready;
  assign off        = idx[3:0];

  // Length completes with the byte at offset 15, so the range check looks through the shift register.
  assign len_full  = LEN_WIDTH'({resp_len, s_data});
  assign end_addr  = {1'b0, resp_addr} + (ADDR_WIDTH+1)'(len_full);
  assign range_bad = (len_full > LEN_MAX) || (end_addr > ADDR_SPAN);
  assign wr_go     = resp_is_write && (len_full != '0) && !range_bad;
  assign last_data = (idx == resp_len - LEN_WIDTH'(1));

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    hdr_bad = 1'b0;
    if (state == CMN)
      hdr_bad = (off == 4'd0 && s_data != 8'h10) || (off == 4'd1 && s_data != 8'h04);
    else if (state == RMA)
      hdr_bad = (off == 4'd5) && (s_data[3:0] != 4'd0 || s_data[7:4] > 4'd1);
  end

  always_comb begin
    state_nxt = state;
    err_inc   = 1'b0;
    pkt_inc   = 1'b0;
    case (state)
      IDLE: if (acc && s_sop) begin
        if (s_eop) err_inc = 1'b1;
        else       state_nxt = (HDR_SKIP == 1) ? CMN : SKIP;
      end
      SKIP: if (acc) begin
        if (s_eop) begin
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end else if (idx == SKIP_LAST) begin
          state_nxt = CMN;
        end
      end
      CMN, RMA: if (acc) begin
        if (state == RMA && off == 4'd15) begin
          if (s_eop)      state_nxt = RESP;
          else if (wr_go) state_nxt = WR_DATA;
          else            state_nxt = DRAIN;
        end else if (s_eop) begin
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end else if (hdr_bad) begin
          state_nxt = DRAIN;
        end else if (state == CMN && off == 4'd3) begin
          state_nxt = RMA;
        end
      end
      WR_DATA: if (acc) begin
        if (s_eop)          state_nxt = RESP;
        else if (last_data) state_nxt = DRAIN;
      end
      DRAIN: if (acc && s_eop) begin
        if (resp_pend) begin
          state_nxt = RESP;
        end else begin
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: if (resp_ready) begin
        state_nxt = IDLE;
        if (resp_status == ST_OK) pkt_inc = 1'b1;
        else                      err_inc = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      resp_pend     <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      resp_is_write <= 1'b0;
      resp_rma_id   <= '0;
      resp_elem_id  <= '0;
      resp_addr     <= '0;
      resp_len      <= '0;
      resp_status   <= ST_OK;
      err_cnt       <= '0;
      pkt_cnt       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; later ones here override the defaults above them.
      mem_we <= 1'b0;
      if (acc) idx <= idx + LEN_WIDTH'(1);
      case (state)
        IDLE: if (acc && s_sop) begin
          idx         <= (HDR_SKIP == 1) ? LEN_WIDTH'(0) : LEN_WIDTH'(1);
          resp_pend   <= 1'b0;
          resp_status <= ST_OK;
        end
        SKIP: if (acc && idx == SKIP_LAST) idx <= '0;
        RMA: if (acc) begin
          case (off)
            4'd4:  resp_rma_id   <= s_data;
            4'd5:  resp_is_write <= (s_data[7:4] == 4'd1);
            4'd6, 4'd7: resp_elem_id <= {resp_elem_id[7:0], s_data};
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13:
                   resp_addr <= ADDR_WIDTH'({resp_addr, s_data});
            4'd14: resp_len <= len_full;
            4'd15: begin
              resp_len  <= len_full;
              resp_pend <= 1'b1;
              idx       <= '0;
              if (range_bad)           resp_status <= ST_BAD_RANGE;
              else if (wr_go && s_eop) resp_status <= ST_TRUNC;
            end
            default: ;
          endcase
        end
        WR_DATA: if (acc) begin
          mem_we    <= 1'b1;
          mem_addr  <= resp_addr + ADDR_WIDTH'(idx);
          mem_wdata <= s_data;
          if (s_eop && !last_data) resp_status <= ST_TRUNC;
        end
        default: ;
      endcase
      if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (pkt_inc && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
endmodule
